// File: rtl/better_neighbor_writer_pkg.sv
// ---------------------------------------------------------------------------
// better_neighbor_writer_pkg: word width, memory map and FSM state encodings
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package better_neighbor_writer_pkg;

  localparam int          WORD_WIDTH   = 16;
  localparam logic [15:0] LIST_BASE    = 16'h68C;
  localparam logic [15:0] QTABLE_BASE  = 16'h600;
  localparam logic [15:0] NEXTHOP_NONE = 16'd100;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_ID = 3'd1,
    S_FETCH_Q  = 3'd2,
    S_EVAL     = 3'd3,
    S_WRITE    = 3'd4,
    S_WR_CNT   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/better_neighbor_writer.sv
// ---------------------------------------------------------------------------
// better_neighbor_writer: scans the neighbor Q-table, writes the better-neighbor list and count word
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module better_neighbor_writer #(
  parameter int                    WORD_WIDTH    = better_neighbor_writer_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] LIST_BASE     = better_neighbor_writer_pkg::LIST_BASE,
  parameter logic [WORD_WIDTH-1:0] QTABLE_BASE   = better_neighbor_writer_pkg::QTABLE_BASE,
  parameter int                    MAX_NEIGHBORS = 16
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] neighbor_count,
  input  logic [WORD_WIDTH-1:0] mybest,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] better_count,
  output logic                  done,
  output logic [7:0]            cstate
);

  import better_neighbor_writer_pkg::*;

  localparam logic [WORD_WIDTH-1:0] MAX_N = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] ONE   = WORD_WIDTH'(1);

  state_t                state;
  logic [WORD_WIDTH-1:0] idx;
  logic [WORD_WIDTH-1:0] count_l;
  logic [WORD_WIDTH-1:0] best_l;
  logic [WORD_WIDTH-1:0] my_id_l;
  logic [WORD_WIDTH-1:0] cand_id;

  logic [WORD_WIDTH-1:0] clamped;
  logic [WORD_WIDTH-1:0] idx_next;
  logic [WORD_WIDTH-1:0] id_addr;
  logic [WORD_WIDTH-1:0] list_addr;
  logic [WORD_WIDTH-1:0] count_next;
  logic                  more;
  logic                  keep;

  assign clamped    = (neighbor_count > MAX_N) ? MAX_N : neighbor_count;
  assign idx_next   = idx + ONE;
  assign id_addr    = QTABLE_BASE + {idx[WORD_WIDTH-2:0], 1'b0};
  assign list_addr  = LIST_BASE + ONE + better_count;
  assign count_next = better_count + ONE;
  assign more       = idx_next < count_l;
  // data_in carries the Q-value while in EVAL
  assign keep       = (data_in < best_l) && (cand_id != my_id_l) && (better_count < MAX_N);

  assign cstate = 8'(state);

  // Write strobes are registered on entry so wr_en is high exactly while in WRITE/WR_CNT
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state        <= S_IDLE;
      address      <= '0;
      data_out     <= '0;
      wr_en        <= 1'b0;
      done         <= 1'b0;
      better_count <= '0;
      idx          <= '0;
      count_l      <= '0;
      best_l       <= '0;
      my_id_l      <= '0;
      cand_id      <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count_l      <= clamped;
            best_l       <= mybest;
            my_id_l      <= MY_NODE_ID;
            better_count <= '0;
            idx          <= '0;
            if (clamped != '0) begin
              state <= S_FETCH_ID;
            end else begin
              state    <= S_WR_CNT;
              address  <= LIST_BASE;
              data_out <= '0;
              wr_en    <= 1'b1;
            end
          end
        end
        S_FETCH_ID: begin
          address <= id_addr;
          state   <= S_FETCH_Q;
        end
        S_FETCH_Q: begin
          address <= id_addr + ONE;
          cand_id <= data_in;
          state   <= S_EVAL;
        end
        S_EVAL: begin
          if (keep) begin
            state    <= S_WRITE;
            address  <= list_addr;
            data_out <= cand_id;
            wr_en    <= 1'b1;
          end else begin
            idx <= idx_next;
            if (more) begin
              state <= S_FETCH_ID;
            end else begin
              state    <= S_WR_CNT;
              address  <= LIST_BASE;
              data_out <= better_count;
              wr_en    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          better_count <= count_next;
          idx          <= idx_next;
          if (more) begin
            state <= S_FETCH_ID;
          end else begin
            state    <= S_WR_CNT;
            address  <= LIST_BASE;
            data_out <= count_next;
            wr_en    <= 1'b1;
          end
        end
        S_WR_CNT: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_better_neighbor_writer.sv
// ---------------------------------------------------------------------------
// tb_better_neighbor_writer: directed vector table plus reset and start-ignore sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_better_neighbor_writer;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] neighbor_count = '0;
  logic [15:0] mybest = '0;
  logic [15:0] my_node_id = '0;
  logic [15:0] data_in;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        wr_en;
  logic [15:0] better_count;
  logic        done;
  logic [7:0]  cstate;

  logic [15:0] mem [0:4095];
  logic [31:0] wlog [$];
  int          checks = 0;
  int          errors = 0;
  int          done_pulses = 0;

  typedef struct {
    int                n;
    logic [19:0][15:0] ids;
    logic [19:0][15:0] qs;
    logic [15:0]       best;
    logic [15:0]       myid;
    int                exp_cnt;
    int                exp_lat;
    logic [15:0][15:0] exp_list;
  } vec_t;

  vec_t vecs [6];

  better_neighbor_writer dut (
    .clock          (clock),
    .nreset         (nreset),
    .start          (start),
    .neighbor_count (neighbor_count),
    .mybest         (mybest),
    .MY_NODE_ID     (my_node_id),
    .data_in        (data_in),
    .address        (address),
    .data_out       (data_out),
    .wr_en          (wr_en),
    .better_count   (better_count),
    .done           (done),
    .cstate         (cstate)
  );

  always #5 clock = ~clock;

  assign data_in = mem[address[11:0]];

  always @(posedge clock) begin
    if (wr_en) wlog.push_back({address, data_out});
  end

  always @(negedge clock) begin
    if (done) done_pulses++;
    if (nreset) begin
      checks++;
      if (wr_en && cstate != 8'd4 && cstate != 8'd5) begin
        errors++;
        $display("FAIL wr_en_state actual cstate=%0d required 4 or 5 while wr_en high", cstate);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_table(input vec_t v);
    for (int i = 0; i < 20; i++) begin
      mem[12'h600 + 2*i]     = v.ids[i];
      mem[12'h600 + 2*i + 1] = v.qs[i];
    end
  endtask

  task automatic run_scan(input vec_t v, input string tag);
    int  k;
    bit  got;
    load_table(v);
    wlog.delete();
    @(negedge clock);
    neighbor_count = v.n[15:0];
    mybest         = v.best;
    my_node_id     = v.myid;
    start          = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    k   = 0;
    got = 1'b0;
    while (!got && k < 300) begin
      @(negedge clock);
      if (done) got = 1'b1;
      else begin
        @(posedge clock);
        k++;
      end
    end
    chk({tag, " latency"}, got ? k + 1 : -1, v.exp_lat);
    chk({tag, " better_count"}, int'(better_count), v.exp_cnt);
    chk({tag, " write_count"}, wlog.size(), v.exp_cnt + 1);
    for (int j = 0; j < v.exp_cnt && j < wlog.size(); j++) begin
      chk({tag, " list_entry"}, int'(wlog[j]), int'({16'h68D + 16'(j), v.exp_list[j]}));
    end
    if (wlog.size() > 0)
      chk({tag, " count_word_last"}, int'(wlog[wlog.size()-1]), int'({16'h68C, 16'(v.exp_cnt)}));
  endtask

  initial begin
    int evals;
    int nw;
    for (int i = 0; i < 4096; i++) mem[i] = 16'hBEEF;

    // vector table: {n, ids, qs, mybest, my id} -> {kept count, latency, list}
    for (int v = 0; v < 6; v++) begin
      vecs[v].ids      = '0;
      vecs[v].qs       = '0;
      vecs[v].exp_list = '0;
    end
    vecs[0].n = 4; vecs[0].best = 16'd20; vecs[0].myid = 16'd7;
    vecs[0].ids[0] = 16'd2; vecs[0].qs[0] = 16'd10;
    vecs[0].ids[1] = 16'd3; vecs[0].qs[1] = 16'd50;
    vecs[0].ids[2] = 16'd7; vecs[0].qs[2] = 16'd5;
    vecs[0].ids[3] = 16'd9; vecs[0].qs[3] = 16'd15;
    vecs[0].exp_cnt = 2; vecs[0].exp_lat = 16;
    vecs[0].exp_list[0] = 16'd2; vecs[0].exp_list[1] = 16'd9;

    vecs[1].n = 0; vecs[1].best = 16'd20; vecs[1].myid = 16'd7;
    vecs[1].exp_cnt = 0; vecs[1].exp_lat = 2;

    vecs[2].n = 3; vecs[2].best = 16'd30; vecs[2].myid = 16'd99;
    for (int i = 0; i < 3; i++) begin
      vecs[2].ids[i] = 16'(i + 1);
      vecs[2].qs[i]  = 16'd30;
    end
    vecs[2].exp_cnt = 0; vecs[2].exp_lat = 11;

    vecs[3].n = 20; vecs[3].best = 16'd1; vecs[3].myid = 16'd99;
    for (int i = 0; i < 20; i++) begin
      vecs[3].ids[i] = 16'(20 + i);
      vecs[3].qs[i]  = 16'd0;
    end
    for (int i = 0; i < 16; i++) vecs[3].exp_list[i] = 16'(20 + i);
    vecs[3].exp_cnt = 16; vecs[3].exp_lat = 3*16 + 16 + 2;

    vecs[4].n = 2; vecs[4].best = 16'd0; vecs[4].myid = 16'd7;
    vecs[4].ids[0] = 16'd4; vecs[4].qs[0] = 16'hFFFF;
    vecs[4].ids[1] = 16'd5; vecs[4].qs[1] = 16'd0;
    vecs[4].exp_cnt = 0; vecs[4].exp_lat = 8;

    vecs[5].n = 2; vecs[5].best = 16'hFFFF; vecs[5].myid = 16'd7;
    vecs[5].ids[0] = 16'd4; vecs[5].qs[0] = 16'hFFFE;
    vecs[5].ids[1] = 16'd5; vecs[5].qs[1] = 16'hFFFF;
    vecs[5].exp_cnt = 1; vecs[5].exp_lat = 9;
    vecs[5].exp_list[0] = 16'd4;

    repeat (3) @(posedge clock);
    #1;
    chk("reset address", int'(address), 0);
    chk("reset data_out", int'(data_out), 0);
    chk("reset wr_en", int'(wr_en), 0);
    chk("reset done", int'(done), 0);
    chk("reset better_count", int'(better_count), 0);
    chk("reset cstate", int'(cstate), 0);
    @(negedge clock);
    nreset = 1'b1;

    for (int v = 0; v < 6; v++) run_scan(vecs[v], $sformatf("vec%0d", v));

    // reset asserted during the second EVAL of a scan
    load_table(vecs[0]);
    wlog.delete();
    @(negedge clock);
    neighbor_count = 16'd4; mybest = 16'd20; my_node_id = 16'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    evals = 0;
    for (int c = 0; c < 100 && evals < 2; c++) begin
      @(negedge clock);
      if (cstate == 8'd3) evals++;
    end
    chk("rst_mid reached second EVAL", evals, 2);
    nreset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_mid wr_en", int'(wr_en), 0);
    chk("rst_mid cstate", int'(cstate), 0);
    chk("rst_mid address", int'(address), 0);
    chk("rst_mid better_count", int'(better_count), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
    nw = 0;
    foreach (wlog[j]) if (wlog[j][31:16] == 16'h68C) nw++;
    chk("rst_mid count_word_writes", nw, 0);
    chk("rst_mid list_writes", wlog.size(), 1);
    run_scan(vecs[0], "after_rst");

    // start pulses in WRITE and DONE must be ignored
    load_table(vecs[0]);
    wlog.delete();
    @(negedge clock);
    done_pulses = 0;
    neighbor_count = 16'd4; mybest = 16'd20; my_node_id = 16'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      start = (cstate == 8'd4 || cstate == 8'd6);
    end
    start = 1'b0;
    @(negedge clock);
    chk("ignore_start done_pulses", done_pulses, 1);
    chk("ignore_start write_count", wlog.size(), 3);
    if (wlog.size() > 0)
      chk("ignore_start count_word", int'(wlog[wlog.size()-1]), int'({16'h68C, 16'd2}));
    chk("ignore_start idle", int'(cstate), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/better_neighbor_writer.md
# better_neighbor_writer

Producer side of the better-neighbor list used by the routing next-hop selector. On `start`, it scans the neighbor Q-table in shared memory and keeps every neighbor whose Q-value beats `mybest`, excluding this node. It writes the kept neighbor IDs into the list region and then writes the count word at the list base, so the selector can later read the count and index the list. The block sits on the same single-port word memory as the selector and runs before it in each routing round.

## Interface
Parameters:
- `WORD_WIDTH`, 16: data and address width.
- `LIST_BASE`, 16'h68C: address of the count word. List entry k is at `LIST_BASE+1+k`.
- `QTABLE_BASE`, 16'h600: neighbor i occupies two words. The ID is at `QTABLE_BASE+2i`; the Q-value is at `QTABLE_BASE+2i+1`.
- `MAX_NEIGHBORS`, 16: list capacity.

Ports:
- `clock`  in  1  clock, rising edge.
- `nreset`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a scan. Sampled only in IDLE.
- `neighbor_count`  in  WORD_WIDTH  number of Q-table entries. Sampled with `start`.
- `mybest`  in  WORD_WIDTH  threshold. Sampled with `start`.
- `MY_NODE_ID`  in  WORD_WIDTH  own ID. Sampled with `start`.
- `data_in`  in  WORD_WIDTH  memory read data. Valid one cycle after `address` is presented.
- `address`  out  WORD_WIDTH  memory address, registered.
- `data_out`  out  WORD_WIDTH  write data, registered.
- `wr_en`  out  1  write strobe. The memory writes `data_out` to `address` on the edge where `wr_en` is high.
- `better_count`  out  WORD_WIDTH  running count of kept neighbors. Holds the final value after done.
- `done`  out  1  single-cycle completion pulse.
- `cstate`  out  8  current state encoding, for debug.

## Operation
- States and encodings:
  - IDLE=0
  - FETCH_ID=1
  - FETCH_Q=2
  - EVAL=3
  - WRITE=4
  - WR_CNT=5
  - DONE=6
- IDLE transitions:
  - On `start`: latch inputs, clear `better_count` and index i.
  - Go to FETCH_ID if the clamped count is nonzero; otherwise go to WR_CNT.
- FETCH_ID: `address<=QTABLE_BASE+2i`.
- FETCH_Q: `address<=QTABLE_BASE+2i+1`. Latch `data_in` as cand_id on the following edge.
- EVAL: `data_in` is the Q-value.
  - Keep the neighbor if unsigned `q < mybest` and `cand_id != MY_NODE_ID` and `better_count < MAX_NEIGHBORS`.
  - If kept, go to WRITE.
  - If not kept, increment i, then go to FETCH_ID if more neighbors remain, else WR_CNT.
- WRITE:
  - Drive `address=LIST_BASE+1+better_count`, `data_out=cand_id`, `wr_en=1`.
  - Increment `better_count`, increment i, then go to FETCH_ID or WR_CNT.
- WR_CNT: drive `address=LIST_BASE`, `data_out=better_count`, `wr_en=1`, then go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Arithmetic: all compares unsigned; address sums wrap modulo 2^WORD_WIDTH.
- Clamping: `neighbor_count > MAX_NEIGHBORS` is clamped to `MAX_NEIGHBORS`.

## Timing
- Reset values: `address=0`, `data_out=0`, `wr_en=0`, `done=0`, `better_count=0`, `cstate=0`.
- Latency, for N scanned neighbors and W kept:
  - Each scanned neighbor costs 3 cycles; each kept neighbor costs 1 extra cycle.
  - `done` is asserted 3N+W+2 cycles after the edge that accepts `start`.
  - N=0 gives 2 cycles.
- `wr_en` is high only in WRITE and WR_CNT. The count word is always the last write.
- `start` outside IDLE is ignored, including in DONE.
- Equal Q-value (`q == mybest`) is not better and is not written.
- List full: further better neighbors are dropped without a write; the scan continues to the end.
- Reset mid-scan: on that edge all outputs return to reset values, with `wr_en` low immediately. The count word is not written, so the list is stale until the next full scan.

## Structure
- Shared package/include holds:
  - `WORD_WIDTH`
  - memory map constants `LIST_BASE=16'h68C`, `QTABLE_BASE`
  - `NEXTHOP_NONE=100`
  - the state encodings
- No sub-module: a single FSM with index, count, and cand_id registers. The memory arbiter is external.

## Test plan
- Four neighbors (2,10),(3,50),(7,5),(9,15); `mybest=20`, `MY_NODE_ID=7` -> writes 0x68D=2, 0x68E=9, then 0x68C=2; `done` 16 cycles after start; `better_count=2`.
- `neighbor_count=0` -> single write 0x68C=0; `done` 2 cycles after start.
- All Q-values equal to `mybest=30` -> no list writes; 0x68C=0.
- `neighbor_count=20`, all better, `MAX_NEIGHBORS=16` -> 16 list writes at 0x68D..0x69C, 0x68C=16, scan clamped to 16 entries.
- `nreset` low during the second EVAL -> next edge `wr_en=0`, `cstate=0`, no count write; a following clean start completes normally.
- `start` pulsed during WRITE and during DONE -> ignored; exactly one `done` pulse.
